// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event decoder.
package keypad_pkg;

  localparam int KEY_NUM = 16;
  localparam int CODE_W  = 4;

  typedef logic [KEY_NUM-1:0] key_vec_t;
  typedef logic [CODE_W-1:0]  key_code_t;

  // Index of the lowest set bit; 0 when the vector is empty (caller gates on |v).
  function automatic key_code_t lowest_set(input key_vec_t v);
    key_code_t idx;
    idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = key_code_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// Synchronous first-word-fall-through FIFO holding key press codes.
module keypad_code_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  key_code_t                din,
  output key_code_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  key_code_t       mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  // Storage write; contents are only meaningful between rptr and wptr.
  // NOTE: the memory array is deliberately not reset -- the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (RST) begin
      rptr  <= '0;
      wptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_decoder.sv
// Debounces the raw keypad vector, detects new presses and queues their key codes.
module keypad_event_decoder
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 5000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          RST,
  input  key_vec_t                      key,
  input  logic                          pop,
  input  logic                          ovf_clr,
  output logic                          code_valid,
  output key_code_t                     code_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output key_vec_t                      key_state
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  key_vec_t         sync1;
  key_vec_t         sync2;
  key_vec_t         raw_p;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [CNT_W-1:0] cnt [KEY_NUM];
  key_vec_t         ks_prev;
  key_vec_t         rise;
  key_vec_t         pend;
  key_code_t        sel_code;
  key_vec_t         sel_mask;
  logic             push_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  // Two-flop synchroniser; released (all ones) out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign raw_p = ~sync2;
  assign tick  = (div == DIV_W'(TICK_DIV - 1));

  // Sample-tick divider: one-cycle tick at TICK_DIV-1, then wrap to 0.
  always_ff @(posedge clk) begin
    if (RST)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DIV_W'(1);
  end

  // Per-key debounce: state flips after DEBOUNCE_TICKS consecutive disagreeing ticks.
  always_ff @(posedge clk) begin
    if (RST) begin
      key_state <= '0;
      for (int i = 0; i < KEY_NUM; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (raw_p[i] == key_state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_TICKS - 1)) begin
          key_state[i] <= raw_p[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Only 0->1 transitions of the debounced level are events; releases are silent.
  assign rise     = key_state & ~ks_prev;
  assign push_req = |pend;
  assign sel_code = lowest_set(pend);
  assign sel_mask = key_vec_t'(1) << sel_code;
  // A full FIFO with no concurrent pop loses the code; the pend bit is still retired.
  assign drop     = push_req & fifo_full & ~pop;

  // Edge history and pending mask: retire the selected bit, land new rises.
  always_ff @(posedge clk) begin
    if (RST) begin
      ks_prev <= '0;
      pend    <= '0;
    end else begin
      ks_prev <= key_state;
      pend    <= (pend & ~sel_mask) | rise;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clk) begin
    if (RST)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  keypad_code_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RST   (RST),
    .push  (push_req),
    .pop   (pop),
    .din   (sel_code),
    .dout  (code_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign code_valid = ~fifo_empty;

endmodule

// File: tb/tb_keypad_event_decoder.sv
// Directed self-checking bench for keypad_event_decoder (TICK_DIV=4, DEBOUNCE_TICKS=3, FIFO_DEPTH=4).
module tb_keypad_event_decoder;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] key;
  logic        pop;
  logic        ovf_clr;
  logic        code_valid;
  logic [3:0]  code_out;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] key_state;

  int n_cmp = 0;
  int n_bad = 0;

  keypad_event_decoder #(
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .key        (key),
    .pop        (pop),
    .ovf_clr    (ovf_clr),
    .code_valid (code_valid),
    .code_out   (code_out),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .key_state  (key_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  // Bounded wait for (key_state & mask) == val; returns right after the edge where it holds.
  task automatic wait_ks(input logic [15:0] mask, input logic [15:0] val, input string tag);
    int n;
    n = 0;
    while (((key_state & mask) != val) && (n < 300)) begin
      step();
      n++;
    end
    check(tag, key_state & mask, val);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".key_state"},  key_state,  0);
    check({tag, ".code_valid"}, code_valid, 0);
    check({tag, ".code_out"},   code_out,   0);
    check({tag, ".fifo_level"}, fifo_level, 0);
    check({tag, ".overflow"},   overflow,   0);
  endtask

  initial begin
    logic [15:0] any_ks;
    logic        any_cv;

    RST = 1'b1; key = 16'hFFFF; pop = 1'b0; ovf_clr = 1'b0;
    step();
    step();
    check_all_zero("reset");

    // Clean press of key 5, released together with reset so tick phase is known:
    // ticks land at edges 4, 8, 12 after release -> key_state at 12, code at 14.
    key = 16'hFFDF;
    RST = 1'b0;
    repeat (11) step();
    check("press.ks_before", key_state, 16'h0000);
    step();
    check("press.ks_flip", key_state, 16'h0020);
    step();
    check("press.cv_edge1", code_valid, 0);
    step();
    check("press.cv_edge2", code_valid, 1);
    check("press.code", code_out, 4'h5);
    check("press.level", fifo_level, 1);
    repeat (60) step();
    check("press.one_entry", fifo_level, 1);
    pop_one();
    check("press.pop_cv", code_valid, 0);
    check("press.pop_code", code_out, 0);
    pop_one();
    check("empty_pop.level", fifo_level, 0);

    // Release produces no new code.
    key = 16'hFFFF;
    wait_ks(16'hFFFF, 16'h0000, "release.ks");
    repeat (10) step();
    check("release.no_code", code_valid, 0);

    // Bounce: toggle at the tick period so every tick sees the opposite level.
    any_ks = '0;
    any_cv = 1'b0;
    for (int t = 0; t < 10; t++) begin
      key = t[0] ? 16'hFFFF : 16'hFFDF;
      for (int c = 0; c < 4; c++) begin
        step();
        any_ks = any_ks | key_state;
        any_cv = any_cv | code_valid;
      end
    end
    key = 16'hFFFF;
    repeat (20) begin
      step();
      any_ks = any_ks | key_state;
      any_cv = any_cv | code_valid;
    end
    check("bounce.ks", any_ks, 0);
    check("bounce.cv", any_cv, 0);

    // Simultaneous press of keys 0 and 15: codes pushed on consecutive clocks.
    key = 16'h7FFE;
    wait_ks(16'hFFFF, 16'h8001, "simul.ks");
    step();
    check("simul.cv_edge1", code_valid, 0);
    step();
    check("simul.code0", code_out, 4'h0);
    check("simul.level1", fifo_level, 1);
    step();
    check("simul.level2", fifo_level, 2);
    pop_one();
    check("simul.codeF", code_out, 4'hF);
    pop_one();
    check("simul.empty", code_valid, 0);
    key = 16'hFFFF;
    wait_ks(16'hFFFF, 16'h0000, "simul.release");

    // Overflow: six presses into a 4-deep FIFO with no pops.
    for (int k = 1; k <= 6; k++) begin
      key = ~(16'h0001 << k);
      wait_ks(16'hFFFF, 16'h0001 << k, "ovf.press");
      key = 16'hFFFF;
      wait_ks(16'hFFFF, 16'h0000, "ovf.release");
    end
    repeat (3) step();
    check("ovf.level", fifo_level, 4);
    check("ovf.flag", overflow, 1);
    check("ovf.head", code_out, 4'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf.clear", overflow, 0);

    // Full FIFO: pop in the same cycle as the push of key 7 keeps the push.
    key = 16'hFF7F;
    wait_ks(16'h0080, 16'h0080, "fullpop.ks");
    step();
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("fullpop.level", fifo_level, 4);
    check("fullpop.ovf", overflow, 0);
    check("fullpop.head", code_out, 4'h2);
    key = 16'hFFFF;
    wait_ks(16'hFFFF, 16'h0000, "fullpop.release");
    pop_one();
    check("fullpop.next", code_out, 4'h3);
    check("fullpop.level3", fifo_level, 3);

    // Reset with 3 entries queued and key 9 held (not yet debounced).
    key = 16'hFDFF;
    step();
    step();
    check("rst.pre_level", fifo_level, 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check_all_zero("rst");
    repeat (13) step();
    check("rst.cv_before", code_valid, 0);
    step();
    check("rst.cv", code_valid, 1);
    check("rst.code9", code_out, 4'h9);
    check("rst.level", fifo_level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
